// File: rtl/tcm_arb_pkg.sv
// Shared definitions for the TCM data-side (stbuf) port arbiter.
//   req_id_t            : identifies which requester owns the read response
//   byte_ranges_overlap : true when two byte ranges [addr, addr+(1<<size)-1]
//                         share at least one byte (computed one bit wider than
//                         the address so a range at the top of memory does not
//                         wrap to zero)
package tcm_arb_pkg;

  // Widest address the overlap helper accepts; callers zero-extend into it.
  localparam int unsigned ARB_ADDR_W_MAX = 64;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_LSU  = 2'd1,
    REQ_DBG  = 2'd2
  } req_id_t;

  function automatic logic byte_ranges_overlap(
    input logic [ARB_ADDR_W_MAX-1:0] addr_a,
    input logic [7:0]                size_a,
    input logic [ARB_ADDR_W_MAX-1:0] addr_b,
    input logic [7:0]                size_b
  );
    logic [ARB_ADDR_W_MAX:0] lo_a;
    logic [ARB_ADDR_W_MAX:0] hi_a;
    logic [ARB_ADDR_W_MAX:0] lo_b;
    logic [ARB_ADDR_W_MAX:0] hi_b;
    lo_a = {1'b0, addr_a};
    lo_b = {1'b0, addr_b};
    hi_a = lo_a + ((65'd1 << size_a) - 65'd1);
    hi_b = lo_b + ((65'd1 << size_b) - 65'd1);
    return (lo_a <= hi_b) && (lo_b <= hi_a);
  endfunction

endpackage

// File: rtl/tcm_arb_starve_ctr.sv
// Debug starvation counter for one arbitration channel.
//   clk, rst  : clock, asynchronous active-low reset
//   pending   : debug request is present on this channel
//   lose      : debug was pending and the competing requester was granted
//   win       : debug was granted on this channel
//   at_limit  : counter has reached STARVE_LIMIT; debug must win next
module tcm_arb_starve_ctr #(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned CNT_WIDTH    = $clog2(STARVE_LIMIT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic pending,
  input  logic lose,
  input  logic win,
  output logic at_limit
);

  localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(STARVE_LIMIT);

  logic [CNT_WIDTH-1:0] r_cnt;

  // A cycle where debug is pending but neither side is granted (read stalled
  // by a write overlap) holds the count rather than advancing it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (win || !pending) begin
      r_cnt <= '0;
    end else if (lose && (r_cnt != LIMIT)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign at_limit = (r_cnt == LIMIT);

endmodule

// File: rtl/tcm_stbuf_arbiter.sv
// Arbiter for the TCM data-side (stbuf) port.
//   Read channel : LSU loads vs debug reads.
//   Write channel: store-buffer drains vs debug writes.
//   The two channels arbitrate independently each cycle; the fixed-priority
//   requester (LSU / store buffer) wins unless the debug port has starved for
//   STARVE_LIMIT cycles on that channel. When the read winner's bytes overlap
//   the write winner's bytes, the read is withheld for a cycle so it observes
//   the new data on retry.
// Ports:
//   clk, rst                         clock, asynchronous active-low reset
//   lsu_rd_*                         LSU load request/grant/response valid
//   stbuf_wr_*                       store-buffer drain request/grant
//   dbg_*                            debug request (dbg_we picks channel),
//                                    grant and read-response valid
//   rd_data                          TCM read data (pass-through)
//   bus_tcm_stbuf_read_*/rd          TCM read command (zero when idle)
//   bus_tcm_stbuf_write_*/data/wr    TCM write command (zero when idle)
//   tcm_bus_stbuf_data               TCM read data, one cycle after rd
module tcm_stbuf_arbiter
  import tcm_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned SIZE_WIDTH     = 2,
  parameter int unsigned REG_DATA_WIDTH = 32,
  parameter int unsigned BUS_DATA_WIDTH = 32,
  parameter int unsigned STARVE_LIMIT   = 8,
  parameter int unsigned CNT_WIDTH      = $clog2(STARVE_LIMIT + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  // LSU loads
  input  logic                      lsu_rd_req,
  input  logic [ADDR_WIDTH-1:0]     lsu_rd_addr,
  input  logic [SIZE_WIDTH-1:0]     lsu_rd_size,
  output logic                      lsu_rd_gnt,
  output logic                      lsu_rd_valid,
  // Store-buffer drain
  input  logic                      stbuf_wr_req,
  input  logic [ADDR_WIDTH-1:0]     stbuf_wr_addr,
  input  logic [SIZE_WIDTH-1:0]     stbuf_wr_size,
  input  logic [REG_DATA_WIDTH-1:0] stbuf_wr_data,
  output logic                      stbuf_wr_gnt,
  // Debug port
  input  logic                      dbg_req,
  input  logic                      dbg_we,
  input  logic [ADDR_WIDTH-1:0]     dbg_addr,
  input  logic [SIZE_WIDTH-1:0]     dbg_size,
  input  logic [REG_DATA_WIDTH-1:0] dbg_wdata,
  output logic                      dbg_gnt,
  output logic                      dbg_rvalid,
  // Read data back to requesters
  output logic [BUS_DATA_WIDTH-1:0] rd_data,
  // TCM stbuf port
  output logic [ADDR_WIDTH-1:0]     bus_tcm_stbuf_read_addr,
  output logic [SIZE_WIDTH-1:0]     bus_tcm_stbuf_read_size,
  output logic                      bus_tcm_stbuf_rd,
  output logic [ADDR_WIDTH-1:0]     bus_tcm_stbuf_write_addr,
  output logic [SIZE_WIDTH-1:0]     bus_tcm_stbuf_write_size,
  output logic [REG_DATA_WIDTH-1:0] bus_tcm_stbuf_data,
  output logic                      bus_tcm_stbuf_wr,
  input  logic [BUS_DATA_WIDTH-1:0] tcm_bus_stbuf_data
);

  logic w_dbg_rd_pend;
  logic w_dbg_wr_pend;
  logic w_rd_at_limit;
  logic w_wr_at_limit;

  // Channel winners before the overlap check.
  logic w_rd_lsu_sel;
  logic w_rd_dbg_sel;
  logic w_wr_stb_sel;
  logic w_wr_dbg_sel;

  logic [ADDR_WIDTH-1:0]     w_rd_addr;
  logic [SIZE_WIDTH-1:0]     w_rd_size;
  logic [ADDR_WIDTH-1:0]     w_wr_addr;
  logic [SIZE_WIDTH-1:0]     w_wr_size;
  logic [REG_DATA_WIDTH-1:0] w_wr_data;

  logic w_overlap;
  logic w_lsu_rd_gnt;
  logic w_dbg_rd_gnt;
  logic w_stb_wr_gnt;
  logic w_dbg_wr_gnt;

  req_id_t r_tag;
  req_id_t w_tag_next;

  assign w_dbg_rd_pend = dbg_req & ~dbg_we;
  assign w_dbg_wr_pend = dbg_req &  dbg_we;

  assign w_rd_dbg_sel = w_dbg_rd_pend & (~lsu_rd_req | w_rd_at_limit);
  assign w_rd_lsu_sel = lsu_rd_req & ~w_rd_dbg_sel;
  assign w_wr_dbg_sel = w_dbg_wr_pend & (~stbuf_wr_req | w_wr_at_limit);
  assign w_wr_stb_sel = stbuf_wr_req & ~w_wr_dbg_sel;

  always_comb begin
    w_rd_addr = '0;
    w_rd_size = '0;
    if (w_rd_lsu_sel) begin
      w_rd_addr = lsu_rd_addr;
      w_rd_size = lsu_rd_size;
    end else if (w_rd_dbg_sel) begin
      w_rd_addr = dbg_addr;
      w_rd_size = dbg_size;
    end
  end

  always_comb begin
    w_wr_addr = '0;
    w_wr_size = '0;
    w_wr_data = '0;
    if (w_wr_stb_sel) begin
      w_wr_addr = stbuf_wr_addr;
      w_wr_size = stbuf_wr_size;
      w_wr_data = stbuf_wr_data;
    end else if (w_wr_dbg_sel) begin
      w_wr_addr = dbg_addr;
      w_wr_size = dbg_size;
      w_wr_data = dbg_wdata;
    end
  end

  // Addresses are zero-extended into the helper's fixed width (ADDR_WIDTH
  // must not exceed ARB_ADDR_W_MAX, SIZE_WIDTH must not exceed 8).
  assign w_overlap = (w_rd_lsu_sel | w_rd_dbg_sel) &
                     (w_wr_stb_sel | w_wr_dbg_sel) &
                     byte_ranges_overlap(ARB_ADDR_W_MAX'(w_rd_addr), 8'(w_rd_size),
                                         ARB_ADDR_W_MAX'(w_wr_addr), 8'(w_wr_size));

  // Grants are forced low while reset is asserted.
  assign w_lsu_rd_gnt = rst & w_rd_lsu_sel & ~w_overlap;
  assign w_dbg_rd_gnt = rst & w_rd_dbg_sel & ~w_overlap;
  assign w_stb_wr_gnt = rst & w_wr_stb_sel;
  assign w_dbg_wr_gnt = rst & w_wr_dbg_sel;

  assign lsu_rd_gnt   = w_lsu_rd_gnt;
  assign stbuf_wr_gnt = w_stb_wr_gnt;
  assign dbg_gnt      = w_dbg_rd_gnt | w_dbg_wr_gnt;

  assign bus_tcm_stbuf_rd         = w_lsu_rd_gnt | w_dbg_rd_gnt;
  assign bus_tcm_stbuf_read_addr  = bus_tcm_stbuf_rd ? w_rd_addr : '0;
  assign bus_tcm_stbuf_read_size  = bus_tcm_stbuf_rd ? w_rd_size : '0;
  assign bus_tcm_stbuf_wr         = w_stb_wr_gnt | w_dbg_wr_gnt;
  assign bus_tcm_stbuf_write_addr = bus_tcm_stbuf_wr ? w_wr_addr : '0;
  assign bus_tcm_stbuf_write_size = bus_tcm_stbuf_wr ? w_wr_size : '0;
  assign bus_tcm_stbuf_data       = bus_tcm_stbuf_wr ? w_wr_data : '0;

  // Debug only "loses" when the competitor actually took the channel.
  tcm_arb_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_WIDTH    (CNT_WIDTH)
  ) u_rd_starve (
    .clk      (clk),
    .rst      (rst),
    .pending  (w_dbg_rd_pend),
    .lose     (w_dbg_rd_pend & w_lsu_rd_gnt),
    .win      (w_dbg_rd_gnt),
    .at_limit (w_rd_at_limit)
  );

  tcm_arb_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_WIDTH    (CNT_WIDTH)
  ) u_wr_starve (
    .clk      (clk),
    .rst      (rst),
    .pending  (w_dbg_wr_pend),
    .lose     (w_dbg_wr_pend & w_stb_wr_gnt),
    .win      (w_dbg_wr_gnt),
    .at_limit (w_wr_at_limit)
  );

  always_comb begin
    w_tag_next = REQ_NONE;
    if (w_lsu_rd_gnt) begin
      w_tag_next = REQ_LSU;
    end else if (w_dbg_rd_gnt) begin
      w_tag_next = REQ_DBG;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tag <= REQ_NONE;
    end else begin
      r_tag <= w_tag_next;
    end
  end

  assign lsu_rd_valid = (r_tag == REQ_LSU);
  assign dbg_rvalid   = (r_tag == REQ_DBG);
  assign rd_data      = tcm_bus_stbuf_data;

endmodule

// File: tb/tb_tcm_stbuf_arbiter.sv
module tb_tcm_stbuf_arbiter;

  logic        clk;
  logic        rst;
  logic        lsu_rd_req;
  logic [31:0] lsu_rd_addr;
  logic [1:0]  lsu_rd_size;
  logic        lsu_rd_gnt;
  logic        lsu_rd_valid;
  logic        stbuf_wr_req;
  logic [31:0] stbuf_wr_addr;
  logic [1:0]  stbuf_wr_size;
  logic [31:0] stbuf_wr_data;
  logic        stbuf_wr_gnt;
  logic        dbg_req;
  logic        dbg_we;
  logic [31:0] dbg_addr;
  logic [1:0]  dbg_size;
  logic [31:0] dbg_wdata;
  logic        dbg_gnt;
  logic        dbg_rvalid;
  logic [31:0] rd_data;
  logic [31:0] bus_raddr;
  logic [1:0]  bus_rsize;
  logic        bus_rd;
  logic [31:0] bus_waddr;
  logic [1:0]  bus_wsize;
  logic [31:0] bus_wdata;
  logic        bus_wr;
  logic [31:0] tcm_rdata;

  int checks;
  int failures;

  tcm_stbuf_arbiter #(
    .ADDR_WIDTH     (32),
    .SIZE_WIDTH     (2),
    .REG_DATA_WIDTH (32),
    .BUS_DATA_WIDTH (32),
    .STARVE_LIMIT   (8)
  ) u_dut (
    .clk                      (clk),
    .rst                      (rst),
    .lsu_rd_req               (lsu_rd_req),
    .lsu_rd_addr              (lsu_rd_addr),
    .lsu_rd_size              (lsu_rd_size),
    .lsu_rd_gnt               (lsu_rd_gnt),
    .lsu_rd_valid             (lsu_rd_valid),
    .stbuf_wr_req             (stbuf_wr_req),
    .stbuf_wr_addr            (stbuf_wr_addr),
    .stbuf_wr_size            (stbuf_wr_size),
    .stbuf_wr_data            (stbuf_wr_data),
    .stbuf_wr_gnt             (stbuf_wr_gnt),
    .dbg_req                  (dbg_req),
    .dbg_we                   (dbg_we),
    .dbg_addr                 (dbg_addr),
    .dbg_size                 (dbg_size),
    .dbg_wdata                (dbg_wdata),
    .dbg_gnt                  (dbg_gnt),
    .dbg_rvalid               (dbg_rvalid),
    .rd_data                  (rd_data),
    .bus_tcm_stbuf_read_addr  (bus_raddr),
    .bus_tcm_stbuf_read_size  (bus_rsize),
    .bus_tcm_stbuf_rd         (bus_rd),
    .bus_tcm_stbuf_write_addr (bus_waddr),
    .bus_tcm_stbuf_write_size (bus_wsize),
    .bus_tcm_stbuf_data       (bus_wdata),
    .bus_tcm_stbuf_wr         (bus_wr),
    .tcm_bus_stbuf_data       (tcm_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Simple little-endian byte TCM: write at posedge, read data registered.
  logic [7:0] mem [0:255];

  function automatic logic [31:0] tcm_read(input logic [31:0] a, input logic [1:0] s);
    logic [31:0] d;
    d = '0;
    for (int i = 0; i < 4; i++) begin
      if (i < (1 << s)) d[8*i +: 8] = mem[a[7:0] + 8'(i)];
    end
    return d;
  endfunction

  always @(posedge clk) begin
    if (bus_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (i < (1 << bus_wsize)) mem[bus_waddr[7:0] + 8'(i)] <= bus_wdata[8*i +: 8];
      end
    end
    if (bus_rd) tcm_rdata <= tcm_read(bus_raddr, bus_rsize);
  end

  typedef struct {
    logic lr; logic [31:0] la; logic [1:0] ls;
    logic sr; logic [31:0] sa; logic [1:0] ss; logic [31:0] sd;
    logic dr; logic dw; logic [31:0] da; logic [1:0] ds; logic [31:0] dd;
    logic e_lg; logic e_sg; logic e_dg; logic e_rd; logic e_wr;
    logic [31:0] e_ra; logic [31:0] e_wa; logic [31:0] e_wd;
    logic e_lv; logic e_dv; logic [31:0] e_mask; logic [31:0] e_data;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s [%0d] actual=0x%h required=0x%h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    lsu_rd_req   = v.lr; lsu_rd_addr   = v.la; lsu_rd_size   = v.ls;
    stbuf_wr_req = v.sr; stbuf_wr_addr = v.sa; stbuf_wr_size = v.ss; stbuf_wr_data = v.sd;
    dbg_req      = v.dr; dbg_we        = v.dw; dbg_addr      = v.da; dbg_size = v.ds; dbg_wdata = v.dd;
  endtask

  task automatic idle();
    lsu_rd_req = 1'b0; lsu_rd_addr = '0; lsu_rd_size = '0;
    stbuf_wr_req = 1'b0; stbuf_wr_addr = '0; stbuf_wr_size = '0; stbuf_wr_data = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_size = '0; dbg_wdata = '0;
  endtask

  logic prev_dg;
  logic exp_dg;

  initial begin
    checks = 0;
    failures = 0;
    tcm_rdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    idle();
    rst = 1'b0;
    lsu_rd_req = 1'b1;

    // Fields: lsu{req,addr,size} stbuf{req,addr,size,data} dbg{req,we,addr,size,wdata}
    //         exp{lsu_gnt,stbuf_gnt,dbg_gnt,rd,wr, raddr,waddr,wdata, lsu_valid,dbg_rvalid,mask,data}
    // Valid/data expectations belong to the previous row's grant.
    vecs.push_back('{1'b0,32'h0,2'd0, 1'b1,32'h0,2'd2,32'h12345678, 1'b0,1'b0,32'h0,2'd0,32'h0,
                     1'b0,1'b1,1'b0,1'b0,1'b1, 32'h0,32'h0,32'h12345678, 1'b0,1'b0,32'h0,32'h0});
    vecs.push_back('{1'b1,32'h0,2'd2, 1'b0,32'h0,2'd0,32'h0, 1'b0,1'b0,32'h0,2'd0,32'h0,
                     1'b1,1'b0,1'b0,1'b1,1'b0, 32'h0,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0});
    vecs.push_back('{1'b0,32'h0,2'd0, 1'b0,32'h0,2'd0,32'h0, 1'b0,1'b0,32'h0,2'd0,32'h0,
                     1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,32'h0,32'h0, 1'b1,1'b0,32'hffffffff,32'h12345678});
    vecs.push_back('{1'b1,32'h3,2'd2, 1'b0,32'h0,2'd0,32'h0, 1'b0,1'b0,32'h0,2'd0,32'h0,
                     1'b1,1'b0,1'b0,1'b1,1'b0, 32'h3,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0});
    vecs.push_back('{1'b0,32'h0,2'd0, 1'b0,32'h0,2'd0,32'h0, 1'b0,1'b0,32'h0,2'd0,32'h0,
                     1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,32'h0,32'h0, 1'b1,1'b0,32'hffffffff,32'h00000012});
    vecs.push_back('{1'b1,32'ha,2'd1, 1'b1,32'h8,2'd2,32'ha5cbeeac, 1'b0,1'b0,32'h0,2'd0,32'h0,
                     1'b0,1'b1,1'b0,1'b0,1'b1, 32'h0,32'h8,32'ha5cbeeac, 1'b0,1'b0,32'h0,32'h0});
    vecs.push_back('{1'b1,32'ha,2'd1, 1'b0,32'h0,2'd0,32'h0, 1'b0,1'b0,32'h0,2'd0,32'h0,
                     1'b1,1'b0,1'b0,1'b1,1'b0, 32'ha,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0});
    vecs.push_back('{1'b0,32'h0,2'd0, 1'b0,32'h0,2'd0,32'h0, 1'b0,1'b0,32'h0,2'd0,32'h0,
                     1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,32'h0,32'h0, 1'b1,1'b0,32'h0000ffff,32'h0000a5cb});
    vecs.push_back('{1'b1,32'h14,2'd2, 1'b1,32'h10,2'd2,32'hcafef00d, 1'b0,1'b0,32'h0,2'd0,32'h0,
                     1'b1,1'b1,1'b0,1'b1,1'b1, 32'h14,32'h10,32'hcafef00d, 1'b0,1'b0,32'h0,32'h0});
    vecs.push_back('{1'b1,32'h10,2'd2, 1'b0,32'h0,2'd0,32'h0, 1'b0,1'b0,32'h0,2'd0,32'h0,
                     1'b1,1'b0,1'b0,1'b1,1'b0, 32'h10,32'h0,32'h0, 1'b1,1'b0,32'hffffffff,32'h0});
    vecs.push_back('{1'b0,32'h0,2'd0, 1'b0,32'h0,2'd0,32'h0, 1'b0,1'b0,32'h0,2'd0,32'h0,
                     1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,32'h0,32'h0, 1'b1,1'b0,32'hffffffff,32'hcafef00d});
    vecs.push_back('{1'b1,32'hc,2'd0, 1'b1,32'h8,2'd2,32'h11223344, 1'b0,1'b0,32'h0,2'd0,32'h0,
                     1'b1,1'b1,1'b0,1'b1,1'b1, 32'hc,32'h8,32'h11223344, 1'b0,1'b0,32'h0,32'h0});
    vecs.push_back('{1'b1,32'h7,2'd1, 1'b1,32'h8,2'd0,32'h55, 1'b0,1'b0,32'h0,2'd0,32'h0,
                     1'b0,1'b1,1'b0,1'b0,1'b1, 32'h0,32'h8,32'h55, 1'b1,1'b0,32'h000000ff,32'h0});
    vecs.push_back('{1'b0,32'h0,2'd0, 1'b0,32'h0,2'd0,32'h0, 1'b1,1'b1,32'h20,2'd2,32'hdeadbeef,
                     1'b0,1'b0,1'b1,1'b0,1'b1, 32'h0,32'h20,32'hdeadbeef, 1'b0,1'b0,32'h0,32'h0});
    vecs.push_back('{1'b0,32'h0,2'd0, 1'b0,32'h0,2'd0,32'h0, 1'b1,1'b0,32'h20,2'd0,32'h0,
                     1'b0,1'b0,1'b1,1'b1,1'b0, 32'h20,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0});
    vecs.push_back('{1'b0,32'h0,2'd0, 1'b0,32'h0,2'd0,32'h0, 1'b0,1'b0,32'h0,2'd0,32'h0,
                     1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,32'h0,32'h0, 1'b0,1'b1,32'h000000ff,32'h000000ef});
    vecs.push_back('{1'b1,32'h48,2'd2, 1'b1,32'h40,2'd2,32'h01020304, 1'b1,1'b1,32'h44,2'd2,32'h99,
                     1'b1,1'b1,1'b0,1'b1,1'b1, 32'h48,32'h40,32'h01020304, 1'b0,1'b0,32'h0,32'h0});
    vecs.push_back('{1'b0,32'h0,2'd0, 1'b0,32'h0,2'd0,32'h0, 1'b0,1'b0,32'h0,2'd0,32'h0,
                     1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,32'h0,32'h0, 1'b1,1'b0,32'hffffffff,32'h0});
    vecs.push_back('{1'b0,32'h0,2'd0, 1'b1,32'h8,2'd0,32'h77, 1'b1,1'b0,32'h7,2'd1,32'h0,
                     1'b0,1'b1,1'b0,1'b0,1'b1, 32'h0,32'h8,32'h77, 1'b0,1'b0,32'h0,32'h0});
    vecs.push_back('{1'b0,32'h0,2'd0, 1'b0,32'h0,2'd0,32'h0, 1'b1,1'b0,32'h7,2'd1,32'h0,
                     1'b0,1'b0,1'b1,1'b1,1'b0, 32'h7,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0});
    vecs.push_back('{1'b0,32'h0,2'd0, 1'b0,32'h0,2'd0,32'h0, 1'b0,1'b0,32'h0,2'd0,32'h0,
                     1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,32'h0,32'h0, 1'b0,1'b1,32'h0000ffff,32'h00007700});

    // Reset state, with an LSU request held to show grants stay low.
    #3;
    check("rst_lsu_gnt",    0, 32'(lsu_rd_gnt),   32'd0);
    check("rst_bus_rd",     0, 32'(bus_rd),       32'd0);
    check("rst_lsu_valid",  0, 32'(lsu_rd_valid), 32'd0);
    check("rst_dbg_rvalid", 0, 32'(dbg_rvalid),   32'd0);
    @(posedge clk); @(posedge clk); #1;
    idle();
    rst = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(negedge clk);
      check("lsu_rd_gnt",   i, 32'(lsu_rd_gnt),   32'(vecs[i].e_lg));
      check("stbuf_wr_gnt", i, 32'(stbuf_wr_gnt), 32'(vecs[i].e_sg));
      check("dbg_gnt",      i, 32'(dbg_gnt),      32'(vecs[i].e_dg));
      check("bus_rd",       i, 32'(bus_rd),       32'(vecs[i].e_rd));
      check("bus_wr",       i, 32'(bus_wr),       32'(vecs[i].e_wr));
      check("read_addr",    i, bus_raddr,         vecs[i].e_ra);
      check("write_addr",   i, bus_waddr,         vecs[i].e_wa);
      check("write_data",   i, bus_wdata,         vecs[i].e_wd);
      check("lsu_rd_valid", i, 32'(lsu_rd_valid), 32'(vecs[i].e_lv));
      check("dbg_rvalid",   i, 32'(dbg_rvalid),   32'(vecs[i].e_dv));
      if (vecs[i].e_mask != 32'h0) check("rd_data", i, rd_data & vecs[i].e_mask, vecs[i].e_data);
      @(posedge clk); #1;
    end

    // Starvation: LSU and debug reads held; debug wins every 9th cycle.
    idle();
    lsu_rd_req = 1'b1; lsu_rd_addr = 32'h50; lsu_rd_size = 2'd2;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h54; dbg_size = 2'd2;
    prev_dg = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      exp_dg = ((k % 9) == 0);
      check("starve_lsu_gnt", k, 32'(lsu_rd_gnt),   32'(!exp_dg));
      check("starve_dbg_gnt", k, 32'(dbg_gnt),      32'(exp_dg));
      check("starve_lsu_vld", k, 32'(lsu_rd_valid), 32'((k > 1) && !prev_dg));
      check("starve_dbg_vld", k, 32'(dbg_rvalid),   32'(prev_dg));
      prev_dg = exp_dg;
      if (k < 22) begin
        @(posedge clk); #1;
      end
    end

    // LSU just granted with the read counter part-way up; reset before the
    // capturing edge must discard the response and restart the counters.
    #1;
    rst = 1'b0;
    #1;
    check("midrst_lsu_gnt", 0, 32'(lsu_rd_gnt), 32'd0);
    check("midrst_dbg_gnt", 0, 32'(dbg_gnt),    32'd0);
    check("midrst_bus_rd",  0, 32'(bus_rd),     32'd0);
    @(negedge clk);
    check("midrst_lsu_vld", 1, 32'(lsu_rd_valid), 32'd0);
    check("midrst_dbg_vld", 1, 32'(dbg_rvalid),   32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      check("post_lsu_gnt", k, 32'(lsu_rd_gnt),   32'(k != 9));
      check("post_dbg_gnt", k, 32'(dbg_gnt),      32'(k == 9));
      check("post_lsu_vld", k, 32'(lsu_rd_valid), 32'(k > 1));
      check("post_dbg_vld", k, 32'(dbg_rvalid),   32'd0);
      @(posedge clk); #1;
    end
    idle();
    @(negedge clk);
    check("post_dbg_vld", 10, 32'(dbg_rvalid),   32'd1);
    check("post_lsu_vld", 10, 32'(lsu_rd_valid), 32'd0);
    check("idle_bus_rd",  10, 32'(bus_rd),       32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
